hilbert_envelope_detector: RTL and testbench

- Downstream stage of the 63-tap Hilbert FIR in the audio path.
- Delays the raw PCM stream by the FIR group delay so it aligns with the FIR's quadrature output.
- Pairs each delayed in-phase sample I with the quadrature sample Q, then computes the envelope floor(sqrt(I²+Q²)) with a sequential 16-iteration integer square root.
- Feeds the envelope/level-meter and visualisation logic.

---
 rtl/hilbert_envelope_detector.sv | 134 +++++++++++++
 tb/tb_hilbert_envelope_detector.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hilbert_envelope_detector.sv
// Aligns raw PCM with Hilbert FIR quadrature output and computes
// envelope floor(sqrt(I^2+Q^2)) with a 16-step restoring square root.
module hilbert_envelope_detector #(
  parameter  int DELAY = 31,
  localparam int DEPTH = DELAY + 1,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic signed [15:0] pcm_in,
  input  logic               valid_in,
  input  logic signed [15:0] hilb_in,
  input  logic               hilb_valid,
  output logic        [15:0] env_out,
  output logic signed [15:0] i_out,
  output logic signed [15:0] q_out,
  output logic               env_valid,
  output logic               busy,
  output logic               overrun
);

  typedef enum logic [1:0] {
    IDLE,
    SQUARE,
    ROOT,
    DONE
  } state_t;

  state_t state, state_nxt;

  logic signed [15:0] mem [DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      wr_ptr_nxt;

  logic signed [15:0] i_reg, q_reg;
  logic [31:0]        rad;
  logic [15:0]        root;
  logic [17:0]        rem;
  logic [3:0]         iter;

  logic signed [31:0] ii, qq;
  logic [31:0]        sum_sq;
  logic [19:0]        rem_sh, trial, rem_nxt;
  logic               ge;
  logic [15:0]        root_nxt;

  assign busy = (state != IDLE);

  assign wr_ptr_nxt = (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;

  // Each square is at most 2^30, so the unsigned sum cannot overflow.
  assign ii     = i_reg * i_reg;
  assign qq     = q_reg * q_reg;
  assign sum_sq = $unsigned(ii) + $unsigned(qq);

  // One restoring step: bring down the next two radicand bits.
  assign rem_sh   = {rem, rad[31:30]};
  assign trial    = {2'b00, root, 2'b01};
  assign ge       = (rem_sh >= trial);
  assign rem_nxt  = ge ? (rem_sh - trial) : rem_sh;
  assign root_nxt = {root[14:0], ge};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:   if (hilb_valid) state_nxt = SQUARE;
      SQUARE: state_nxt = ROOT;
      ROOT:   if (iter == 4'd0) state_nxt = DONE;
      DONE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
      wr_ptr    <= '0;
      i_reg     <= '0;
      q_reg     <= '0;
      rad       <= '0;
      root      <= '0;
      rem       <= '0;
      iter      <= '0;
      env_out   <= '0;
      i_out     <= '0;
      q_out     <= '0;
      env_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      env_valid <= 1'b0;
      if (valid_in) begin
        mem[wr_ptr] <= pcm_in;
        wr_ptr      <= wr_ptr_nxt;
      end
      if (hilb_valid && state != IDLE) overrun <= 1'b1;
      unique case (state)
        IDLE: begin
          if (hilb_valid) begin
            i_reg <= mem[wr_ptr];
            q_reg <= hilb_in;
          end
        end
        SQUARE: begin
          rad  <= sum_sq;
          root <= '0;
          rem  <= '0;
          iter <= 4'd15;
        end
        ROOT: begin
          rad  <= {rad[29:0], 2'b00};
          root <= root_nxt;
          rem  <= rem_nxt[17:0];
          iter <= iter - 4'd1;
        end
        DONE: begin
          env_out   <= root;
          i_out     <= i_reg;
          q_out     <= q_reg;
          env_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hilbert_envelope_detector.sv
// Directed and random checks for hilbert_envelope_detector:
// alignment, sqrt accuracy, latency, overrun and reset behaviour.
module tb_hilbert_envelope_detector;

  logic               clk = 1'b0;
  logic               rst;
  logic signed [15:0] pcm_in;
  logic               valid_in;
  logic signed [15:0] hilb_in;
  logic               hilb_valid;
  logic        [15:0] env_out;
  logic signed [15:0] i_out;
  logic signed [15:0] q_out;
  logic               env_valid;
  logic               busy;
  logic               overrun;

  int checks = 0;
  int errors = 0;

  logic signed [15:0] hist [$];
  logic signed [15:0] exp_i;

  hilbert_envelope_detector dut (
    .clk        (clk),
    .rst        (rst),
    .pcm_in     (pcm_in),
    .valid_in   (valid_in),
    .hilb_in    (hilb_in),
    .hilb_valid (hilb_valid),
    .env_out    (env_out),
    .i_out      (i_out),
    .q_out      (q_out),
    .env_valid  (env_valid),
    .busy       (busy),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  function automatic longint isqrt(input longint s);
    longint r;
    r = longint'($sqrt(real'(s)));
    while (r * r > s) r--;
    while ((r + 1) * (r + 1) <= s) r++;
    return r;
  endfunction

  // One-cycle drive of the strobes; tracks raw history for I.
  task automatic send(input bit vin, input logic signed [15:0] pcm,
                      input bit hv, input logic signed [15:0] q);
    valid_in   = vin;
    pcm_in     = pcm;
    hilb_valid = hv;
    hilb_in    = q;
    if (hv) exp_i = (hist.size() >= 32) ? hist[hist.size() - 32] : 16'sd0;
    if (vin) hist.push_back(pcm);
    @(posedge clk);
    #1;
    valid_in   = 1'b0;
    hilb_valid = 1'b0;
  endtask

  task automatic wait_env(output bit got);
    got = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (env_valid) begin
        got = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    hist.delete();
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (env_out !== 16'd0 || i_out !== 16'sd0 || q_out !== 16'sd0) begin
      errors++;
      $display("FAIL reset_data env=%0d i=%0d q=%0d want 0", env_out, i_out, q_out);
    end
    checks++;
    if ({env_valid, busy, overrun} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags got %b want 000", {env_valid, busy, overrun});
    end
  endtask

  task automatic test_triple();
    bit got;
    for (int n = 0; n < 31; n++) send(1'b1, 16'sd0, 1'b0, 16'sd0);
    send(1'b1, 16'sd3000, 1'b0, 16'sd0);
    for (int n = 0; n < 31; n++) begin
      send(1'b1, 16'sd0, 1'b0, 16'sd0);
      send(1'b0, 16'sd0, 1'b1, 16'sd0);
      wait_env(got);
    end
    send(1'b0, 16'sd0, 1'b1, 16'sd4000);
    wait_env(got);
    checks++;
    if (!got || env_out !== 16'd5000 || i_out !== 16'sd3000 || q_out !== 16'sd4000) begin
      errors++;
      $display("FAIL triple got=%0b env=%0d i=%0d q=%0d want 5000 3000 4000",
               got, env_out, i_out, q_out);
    end
  endtask

  task automatic test_extremes();
    bit got;
    send(1'b1, -16'sd32768, 1'b0, 16'sd0);
    send(1'b1, 16'sd0, 1'b0, 16'sd0);
    send(1'b1, 16'sd1, 1'b0, 16'sd0);
    for (int n = 0; n < 29; n++) send(1'b1, 16'sd0, 1'b0, 16'sd0);
    send(1'b1, 16'sd0, 1'b1, -16'sd32768);
    wait_env(got);
    checks++;
    if (!got || env_out !== 16'd46340 || i_out !== -16'sd32768) begin
      errors++;
      $display("FAIL extreme_max got=%0b env=%0d i=%0d want 46340 -32768", got, env_out, i_out);
    end
    send(1'b1, 16'sd0, 1'b1, 16'sd0);
    wait_env(got);
    checks++;
    if (!got || env_out !== 16'd0 || i_out !== 16'sd0) begin
      errors++;
      $display("FAIL extreme_zero got=%0b env=%0d i=%0d want 0 0", got, env_out, i_out);
    end
    send(1'b1, 16'sd0, 1'b1, 16'sd1);
    wait_env(got);
    checks++;
    if (!got || env_out !== 16'd1 || i_out !== 16'sd1 || q_out !== 16'sd1) begin
      errors++;
      $display("FAIL extreme_one got=%0b env=%0d i=%0d q=%0d want 1 1 1",
               got, env_out, i_out, q_out);
    end
  endtask

  task automatic test_fill();
    bit got;
    logic [15:0] want;
    apply_reset();
    for (int n = 0; n < 32; n++) begin
      send(1'b1, (n == 0) ? 16'sd1000 : 16'sd0, 1'b0, 16'sd0);
      send(1'b0, 16'sd0, 1'b1, 16'sd0);
      wait_env(got);
      want = (n == 31) ? 16'd1000 : 16'd0;
      checks++;
      if (!got || env_out !== want) begin
        errors++;
        $display("FAIL fill_%0d got=%0b env=%0d want %0d", n, got, env_out, want);
      end
    end
    // Buffer slot being overwritten still holds the impulse.
    send(1'b1, 16'sd0, 1'b1, 16'sd0);
    wait_env(got);
    checks++;
    if (!got || env_out !== 16'd1000 || i_out !== 16'sd1000) begin
      errors++;
      $display("FAIL fill_prewrite got=%0b env=%0d i=%0d want 1000", got, env_out, i_out);
    end
    for (int n = 33; n < 40; n++) begin
      send(1'b1, 16'sd0, 1'b0, 16'sd0);
      send(1'b0, 16'sd0, 1'b1, 16'sd0);
      wait_env(got);
      checks++;
      if (!got || env_out !== 16'd0) begin
        errors++;
        $display("FAIL fill_%0d got=%0b env=%0d want 0", n, got, env_out);
      end
    end
  endtask

  task automatic test_latency_overrun();
    apply_reset();
    checks++;
    if (overrun !== 1'b0) begin
      errors++;
      $display("FAIL overrun_init got %b want 0", overrun);
    end
    hilb_valid = 1'b1;
    hilb_in    = 16'sd700;
    @(posedge clk);
    #1;
    hilb_valid = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_e0 got %b want 1", busy);
    end
    for (int k = 1; k <= 20; k++) begin
      if (k == 5) begin
        hilb_valid = 1'b1;
        hilb_in    = 16'sd123;
      end
      @(posedge clk);
      #1;
      hilb_valid = 1'b0;
      checks++;
      if (env_valid !== 1'(k == 18) || busy !== 1'(k <= 17)) begin
        errors++;
        $display("FAIL latency_e%0d env_valid=%b busy=%b want %b %b",
                 k, env_valid, busy, 1'(k == 18), 1'(k <= 17));
      end
    end
    checks++;
    if (overrun !== 1'b1 || env_out !== 16'd700 || q_out !== 16'sd700 || i_out !== 16'sd0) begin
      errors++;
      $display("FAIL overrun ovr=%b env=%0d q=%0d i=%0d want 1 700 700 0",
               overrun, env_out, q_out, i_out);
    end
  endtask

  task automatic test_reset_mid();
    bit got;
    int seen;
    for (int n = 0; n < 32; n++) send(1'b1, 16'sd500, 1'b0, 16'sd0);
    hilb_valid = 1'b1;
    hilb_in    = 16'sd0;
    @(posedge clk);
    #1;
    hilb_valid = 1'b0;
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    #1;
    checks++;
    if (env_out !== 16'd0 || i_out !== 16'sd0 || q_out !== 16'sd0 ||
        {busy, env_valid, overrun} !== 3'b000) begin
      errors++;
      $display("FAIL reset_mid env=%0d i=%0d q=%0d flags=%b want 0",
               env_out, i_out, q_out, {busy, env_valid, overrun});
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    hist.delete();
    seen = 0;
    for (int k = 0; k < 25; k++) begin
      @(posedge clk);
      #1;
      if (env_valid) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL reset_abandon env_valid pulses=%0d want 0", seen);
    end
    send(1'b0, 16'sd0, 1'b1, 16'sd300);
    wait_env(got);
    checks++;
    if (!got || env_out !== 16'd300 || i_out !== 16'sd0) begin
      errors++;
      $display("FAIL reset_cleared got=%0b env=%0d i=%0d want 300 0", got, env_out, i_out);
    end
  endtask

  task automatic test_random();
    bit got;
    logic signed [15:0] p, q;
    longint s;
    logic [15:0] want;
    for (int n = 0; n < 1000; n++) begin
      p = 16'($urandom);
      q = 16'($urandom);
      send(1'b1, p, 1'b1, q);
      wait_env(got);
      s    = longint'(exp_i) * longint'(exp_i) + longint'(q) * longint'(q);
      want = 16'(isqrt(s));
      checks++;
      if (!got || env_out !== want || i_out !== exp_i || q_out !== q) begin
        errors++;
        $display("FAIL random_%0d got=%0b env=%0d i=%0d q=%0d want %0d %0d %0d",
                 n, got, env_out, i_out, q_out, want, exp_i, q);
      end
    end
  endtask

  initial begin
    rst        = 1'b1;
    pcm_in     = '0;
    valid_in   = 1'b0;
    hilb_in    = '0;
    hilb_valid = 1'b0;
    exp_i      = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    test_reset();
    test_triple();
    test_extremes();
    test_fill();
    test_latency_overrun();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
